// File: rtl/shader_sequencer.sv
// Sequencer for the SIMD shader datapath: start/done handshake, bounded program
// length, registered one-cycle writeback and read-after-write stall on the pending write.
module shader_sequencer #(
  parameter int PC_W   = 4,
  parameter int RA_W   = 3,
  parameter int MASK_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [PC_W-1:0]   prog_last,
  input  logic [MASK_W-1:0] inst_mask,
  input  logic [RA_W-1:0]   inst_dest,
  input  logic [RA_W-1:0]   inst_srcA,
  input  logic [RA_W-1:0]   inst_srcB,
  output logic [PC_W-1:0]   pc,
  output logic              issue,
  output logic              wb_en,
  output logic [RA_W-1:0]   wb_addr,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  instr_cnt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [PC_W-1:0] last_q;
  logic            hazard;
  logic            at_last;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // The register file writes on posedge and reads combinationally, so only the
  // single in-flight writeback can collide with the current instruction's sources.
  assign hazard = wb_en && (|inst_mask) &&
                  ((inst_srcA == wb_addr) || (inst_srcB == wb_addr));
  assign at_last   = (pc == last_q);
  assign fsm_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Handshake: start is accepted only in IDLE; done pulses for exactly one cycle
  // after the last writeback; abort (any state) returns to IDLE without done.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (issue && at_last) next_state = DRAIN;
      DRAIN:   next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (abort) next_state = IDLE;
  end

  always_comb begin
    issue = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      RUN: begin
        issue = !hazard;
        busy  = 1'b1;
      end
      DRAIN:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= '0;
      wb_en     <= 1'b0;
      wb_addr   <= '0;
      instr_cnt <= '0;
      stall_cnt <= '0;
      last_q    <= '0;
    end else begin
      wb_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            pc        <= '0;
            instr_cnt <= '0;
            stall_cnt <= '0;
            last_q    <= prog_last;
          end
        end
        RUN: begin
          if (issue) begin
            // An abort on this edge drops the writeback but the fetch still advances.
            wb_en     <= (|inst_mask) && !abort;
            wb_addr   <= inst_dest;
            instr_cnt <= sat_inc(instr_cnt);
            if (!at_last) pc <= pc + PC_W'(1);
          end else begin
            stall_cnt <= sat_inc(stall_cnt);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shader_sequencer.sv
// Bench for shader_sequencer: directed programs plus random programs checked
// against an instruction-level model of issue, stall and writeback timing.
module tb_shader_sequencer;

  localparam int PC_W    = 4;
  localparam int RA_W    = 3;
  localparam int MASK_W  = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int DEPTH   = 1 << PC_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              abort;
  logic [PC_W-1:0]   prog_last;
  logic [MASK_W-1:0] inst_mask;
  logic [RA_W-1:0]   inst_dest;
  logic [RA_W-1:0]   inst_srcA;
  logic [RA_W-1:0]   inst_srcB;
  logic [PC_W-1:0]   pc;
  logic              issue;
  logic              wb_en;
  logic [RA_W-1:0]   wb_addr;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  instr_cnt;
  logic [CNT_W-1:0]  stall_cnt;
  logic [1:0]        fsm_state;

  logic [MASK_W-1:0] pm_mask [DEPTH];
  logic [RA_W-1:0]   pm_dest [DEPTH];
  logic [RA_W-1:0]   pm_srcA [DEPTH];
  logic [RA_W-1:0]   pm_srcB [DEPTH];

  typedef struct packed {
    logic            issue;
    logic [PC_W-1:0] pc;
    logic            wb_en;
    logic [RA_W-1:0] wb_addr;
    logic            busy;
    logic            done;
  } cyc_t;

  cyc_t exp_q[$];
  int   exp_instr;
  int   exp_stall;
  int   checks = 0;
  int   errors = 0;

  shader_sequencer #(
    .PC_W(PC_W), .RA_W(RA_W), .MASK_W(MASK_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .prog_last(prog_last),
    .inst_mask(inst_mask), .inst_dest(inst_dest), .inst_srcA(inst_srcA),
    .inst_srcB(inst_srcB), .pc(pc), .issue(issue), .wb_en(wb_en),
    .wb_addr(wb_addr), .busy(busy), .done(done), .instr_cnt(instr_cnt),
    .stall_cnt(stall_cnt), .fsm_state(fsm_state)
  );

  // Clock / reset block and program memory
  always #5 clk = ~clk;

  assign inst_mask = pm_mask[pc];
  assign inst_dest = pm_dest[pc];
  assign inst_srcA = pm_srcA[pc];
  assign inst_srcB = pm_srcB[pc];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_cycle(input logic iss, input int p, input logic we,
                            input logic [RA_W-1:0] wa, input logic b, input logic d);
    cyc_t c;
    c.issue   = iss;
    c.pc      = PC_W'(p);
    c.wb_en   = we;
    c.wb_addr = wa;
    c.busy    = b;
    c.done    = d;
    exp_q.push_back(c);
  endtask

  // Instruction-level model: each instruction issues once, preceded by one bubble
  // when it reads the register written by the instruction issued just before it.
  task automatic build_model(input int last);
    bit              prev_wr;
    logic [RA_W-1:0] prev_dest;
    int              n_instr;
    int              n_stall;
    exp_q.delete();
    prev_wr   = 1'b0;
    prev_dest = '0;
    n_instr   = 0;
    n_stall   = 0;
    for (int i = 0; i <= last; i++) begin
      if (prev_wr && pm_mask[i] != 0 &&
          (pm_srcA[i] == prev_dest || pm_srcB[i] == prev_dest)) begin
        push_cycle(1'b0, i, 1'b1, prev_dest, 1'b1, 1'b0);
        prev_wr = 1'b0;
        n_stall++;
      end
      push_cycle(1'b1, i, prev_wr, prev_dest, 1'b1, 1'b0);
      prev_wr   = (pm_mask[i] != 0);
      prev_dest = pm_dest[i];
      n_instr++;
    end
    push_cycle(1'b0, last, prev_wr, prev_dest, 1'b1, 1'b0);
    push_cycle(1'b0, last, 1'b0, prev_dest, 1'b0, 1'b1);
    exp_instr = (n_instr > CNT_MAX) ? CNT_MAX : n_instr;
    exp_stall = (n_stall > CNT_MAX) ? CNT_MAX : n_stall;
  endtask

  // Driver tasks
  task automatic load_linear();
    for (int i = 0; i < DEPTH; i++) begin
      pm_mask[i] = '1;
      pm_dest[i] = RA_W'(i % 7);
      pm_srcA[i] = 3'd7;
      pm_srcB[i] = 3'd7;
    end
  endtask

  task automatic load_random();
    for (int i = 0; i < DEPTH; i++) begin
      pm_mask[i] = ($urandom_range(0, 3) == 0) ? '0 : MASK_W'($urandom_range(1, 15));
      pm_dest[i] = RA_W'($urandom_range(0, 7));
      pm_srcA[i] = RA_W'($urandom_range(0, 7));
      pm_srcB[i] = RA_W'($urandom_range(0, 7));
    end
  endtask

  // glitch: 0 none, 1 start pulse in the second busy cycle, 2 start pulse in DONE
  task automatic run_prog(input int last, input int glitch);
    int gk;
    cyc_t c;
    build_model(last);
    gk = (glitch == 1) ? 1 : (glitch == 2) ? exp_q.size() - 1 : -1;
    prog_last = PC_W'(last);
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    prog_last = PC_W'($urandom);
    for (int k = 0; k < exp_q.size(); k++) begin
      c = exp_q[k];
      if (k == gk) start = 1'b1;
      #1;
      chk($sformatf("issue@%0d", k), issue, c.issue);
      chk($sformatf("pc@%0d", k), pc, c.pc);
      chk($sformatf("wb_en@%0d", k), wb_en, c.wb_en);
      if (c.wb_en) chk($sformatf("wb_addr@%0d", k), wb_addr, c.wb_addr);
      chk($sformatf("busy@%0d", k), busy, c.busy);
      chk($sformatf("done@%0d", k), done, c.done);
      if (k == 0) begin
        chk("instr_cnt_clr", instr_cnt, 0);
        chk("stall_cnt_clr", stall_cnt, 0);
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_wb_en", wb_en, 0);
    chk("idle_pc", pc, last);
    chk("instr_cnt", instr_cnt, exp_instr);
    chk("stall_cnt", stall_cnt, exp_stall);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    prog_last = '0;
    load_linear();
    #3;
    chk("rst_pc", pc, 0);
    chk("rst_wb_en", wb_en, 0);
    chk("rst_wb_addr", wb_addr, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_issue", issue, 0);
    chk("rst_instr_cnt", instr_cnt, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    #9 rst = 1'b0;
    @(posedge clk); #2;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_pc", pc, 0);

    // Straight-line program, no register overlap
    load_linear();
    run_prog(3, 0);
    chk("line_instr", instr_cnt, 4);
    chk("line_stall", stall_cnt, 0);

    // Back-to-back read-after-write
    pm_mask[0] = '1; pm_dest[0] = 3'd2; pm_srcA[0] = 3'd7; pm_srcB[0] = 3'd7;
    pm_mask[1] = '1; pm_dest[1] = 3'd3; pm_srcA[1] = 3'd2; pm_srcB[1] = 3'd7;
    run_prog(1, 0);
    chk("raw_instr", instr_cnt, 2);
    chk("raw_stall", stall_cnt, 1);

    // NOP never writes, so its destination cannot cause a stall
    pm_mask[0] = '0; pm_dest[0] = 3'd5; pm_srcA[0] = 3'd7; pm_srcB[0] = 3'd7;
    pm_mask[1] = '1; pm_dest[1] = 3'd1; pm_srcA[1] = 3'd7; pm_srcB[1] = 3'd5;
    run_prog(1, 0);
    chk("nop_stall", stall_cnt, 0);

    // start and abort together in IDLE: stay idle
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    #1;
    chk("sa_busy", busy, 0);
    chk("sa_pc", pc, 1);
    @(posedge clk); #2;
    chk("sa_busy2", busy, 0);
    chk("sa_done", done, 0);

    // Abort at pc=3 while pc2's writeback is pending
    load_linear();
    prog_last = 4'd7;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_pre_pc", pc, 3);
    chk("abort_pre_wb", wb_en, 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    #1;
    chk("abort_pc", pc, 4);
    chk("abort_wb_en", wb_en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_issue", issue, 0);
    @(posedge clk); #2;
    chk("abort_done2", done, 0);
    chk("abort_pc2", pc, 4);

    // Full range with ignored starts, then restart; instr_cnt saturates
    load_random();
    run_prog(15, 1);
    chk("full_sat", instr_cnt, CNT_MAX);
    run_prog(15, 2);
    chk("full_sat2", instr_cnt, CNT_MAX);

    repeat (8) begin
      load_random();
      run_prog($urandom_range(0, 15), $urandom_range(0, 2));
    end

    // Async reset between edges during RUN
    load_random();
    prog_last = 4'd15;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #4 rst = 1'b1;
    #1;
    chk("arst_pc", pc, 0);
    chk("arst_wb_en", wb_en, 0);
    chk("arst_done", done, 0);
    chk("arst_busy", busy, 0);
    chk("arst_issue", issue, 0);
    chk("arst_instr", instr_cnt, 0);
    @(posedge clk);
    #4 rst = 1'b0;
    @(posedge clk); #2;
    chk("arst_idle_busy", busy, 0);
    chk("arst_idle_pc", pc, 0);
    chk("arst_idle_wb", wb_en, 0);
    chk("arst_idle_issue", issue, 0);
    chk("arst_idle_done", done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shader_sequencer.md
Name: shader_sequencer

Overview:
Control block that sequences the SIMD shader datapath: program counter, instruction memory, vector register file and SIMD ALU. It replaces free-running PC increment with a start/done handshake, a bounded program length, a registered one-cycle writeback stage and read-after-write hazard stalls. The program memory, register file and ALU stay as they are; this block drives their PC and write controls.

Parameters:
PC_W, 4, program counter width; program holds up to 2^PC_W instructions
RA_W, 3, register address width (8 vector registers)
MASK_W, 4, lane mask width (one bit per SIMD lane)
CNT_W, 8, width of the saturating statistics counters

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  asynchronous active-high reset
start  in  1  begin execution at PC 0; sampled only in IDLE
abort  in  1  terminate execution; return to IDLE; drop pending writeback
prog_last  in  PC_W  index of the last instruction; latched at start
inst_mask  in  MASK_W  lane mask of the instruction at pc; 0 = NOP
inst_dest  in  RA_W  destination register of the instruction at pc
inst_srcA  in  RA_W  source A of the instruction at pc
inst_srcB  in  RA_W  source B of the instruction at pc
pc  out  PC_W  instruction address to program memory
issue  out  1  combinational; ALU result is valid and must be captured into result_reg this cycle
wb_en  out  1  registered register-file write enable
wb_addr  out  RA_W  registered register-file write address
busy  out  1  high in RUN and DRAIN
done  out  1  one-cycle pulse in DONE
instr_cnt  out  CNT_W  instructions issued in the current or last run, including NOPs; saturating
stall_cnt  out  CNT_W  hazard stall cycles in the current or last run; saturating

Behaviour:
- Reset (async): state=IDLE, pc=0, wb_en=0, wb_addr=0, done=0, instr_cnt=0, stall_cnt=0, latched prog_last=0.
- States: IDLE, RUN, DRAIN, DONE. There is no other encoding. Any unreachable encoding returns to IDLE.
- IDLE:
  - start=1 at an edge: pc<=0, instr_cnt<=0, stall_cnt<=0, latch prog_last, go to RUN.
  - Otherwise hold. pc and the counters keep their last values.
- Hazard (combinational): hazard = wb_en && inst_mask!=0 && (inst_srcA==wb_addr || inst_srcB==wb_addr).
  - The register file reads combinationally and writes on posedge, so the dependent instruction waits exactly one cycle.
- RUN:
  - issue = !hazard.
  - On issue: wb_en<=(inst_mask!=0), wb_addr<=inst_dest, instr_cnt increments.
    - If pc==latched prog_last, go to DRAIN and hold pc.
    - Otherwise pc<=pc+1.
  - On hazard: pc holds, wb_en<=0 (bubble), stall_cnt increments.
- DRAIN: issue=0. wb_en for the last instruction is high during the first DRAIN cycle. wb_en<=0, go to DONE.
- DONE: done=1, busy=0, wb_en=0, go to IDLE. A start during DONE is ignored.
- abort=1 at an edge in any state other than IDLE: go to IDLE, wb_en<=0.
  - A writeback pending for that edge is dropped.
  - done is not pulsed.
  - abort has priority over every other transition.
- start outside IDLE is ignored. start and abort together in IDLE: abort wins and the block stays in IDLE.
- pc never wraps during a run. prog_last=2^PC_W-1 runs all entries and ends via DRAIN.
- A NOP (inst_mask=0) issues, advances pc and counts. It never writes and never stalls.
- Counters saturate at 2^CNT_W-1.
- The sequencer is the only source of wb_en and wb_addr for the register file.

Test Plan:
- Straight-line program: prog_last=3, no register overlaps, start pulse at edge E0 -> issue high for 4 cycles (pc 0..3), wb_en high after E1..E4 with wb_addr = dests in order, done pulse after E5, busy low after E5, instr_cnt=4, stall_cnt=0.
- Back-to-back RAW: pc0 dest=R2, pc1 srcA=R2, prog_last=1 -> one stall cycle with pc=1 and issue=0, then pc1 issues, instr_cnt=2, stall_cnt=1, done 1 cycle later than the no-hazard case.
- NOP masking: pc0 mask=0 dest=R5, pc1 srcB=R5 -> no wb_en for pc0, no stall, stall_cnt=0.
- Abort mid-run: prog_last=7, abort asserted with pc=3 while a writeback is pending -> IDLE after that edge, wb_en=0 at that edge, no done pulse, pc holds 4.
- Full-range and ignored start: prog_last=15 -> 16 issues, pc stops at 15 without wrapping, done pulses. A start asserted during RUN and DONE has no effect. A second start from IDLE restarts at pc=0 with counters cleared.
- Async reset: assert rst between clock edges in RUN -> wb_en, done and pc go to 0 immediately, state is IDLE, and the first edge after release with start=0 causes no activity.
